// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle MUL/DIV sequencer: opcodes, FSM states
// and the latency helper.
package muldiv_seq_pkg;

  localparam logic [4:0] ALU_MUL = 5'b01100;
  localparam logic [4:0] ALU_DIV = 5'b01101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of CALC edges needed to retire all XLEN bits.
  function automatic int calc_lat(input int xlen, input int bits_per_cycle);
    return xlen / bits_per_cycle;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the execute stage (master) and the MUL/DIV
// sequencer (slave).
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic [4:0]      ALUSignal;
  logic [XLEN-1:0] AiA;
  logic [XLEN-1:0] AiB;
  logic            start;
  logic            flush;
  logic            result_ack;
  logic            req_ready;
  logic            busy;
  logic [XLEN-1:0] Aout;
  logic            AZout;
  logic            result_valid;
  logic            mode;

  modport master (
    output ALUSignal, AiA, AiB, start, flush, result_ack,
    input  req_ready, busy, Aout, AZout, result_valid, mode
  );

  modport slave (
    input  ALUSignal, AiA, AiB, start, flush, result_ack,
    output req_ready, busy, Aout, AZout, result_valid, mode
  );
endinterface

// File: rtl/muldiv_seq_step.sv
// One iteration of shift-add multiply (mode=0) or restoring divide (mode=1).
// Purely combinational so several copies can be chained per clock.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            mode,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o
);
  // One extra bit keeps the compare exact when the divisor has its MSB set.
  logic [XLEN:0] rem_shift;
  logic [XLEN:0] rem_diff;

  always_comb begin
    rem_shift = {acc_i, a_i[XLEN-1]};
    rem_diff  = rem_shift - {1'b0, b_i};
    acc_o     = acc_i;
    a_o       = a_i;
    b_o       = b_i;
    if (mode) begin
      // a_i holds the dividend and collects quotient bits from the bottom.
      if (rem_shift >= {1'b0, b_i}) begin
        acc_o = rem_diff[XLEN-1:0];
        a_o   = {a_i[XLEN-2:0], 1'b1};
      end else begin
        acc_o = rem_shift[XLEN-1:0];
        a_o   = {a_i[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_o = acc_i + (b_i[0] ? a_i : '0);
      a_o   = {a_i[XLEN-2:0], 1'b0};
      b_o   = {1'b0, b_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer: accepts one request, iterates BITS_PER_CYCLE
// bits per clock, and holds the result until the execute stage acknowledges it.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input logic        clk,
  input logic        rst,
  muldiv_seq_if.slave bus
);
  localparam int LAT   = calc_lat(XLEN, BITS_PER_CYCLE);
  localparam int CNT_W = ($clog2(LAT) > 0) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            mode_q, mode_d;
  logic [XLEN-1:0] aout_q, aout_d;
  logic            az_q, az_d;
  logic            rv_q, rv_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;

  logic [XLEN-1:0] acc_c [0:BITS_PER_CYCLE];
  logic [XLEN-1:0] a_c   [0:BITS_PER_CYCLE];
  logic [XLEN-1:0] b_c   [0:BITS_PER_CYCLE];
  logic [XLEN-1:0] result_w;
  logic            is_mul, is_div, accept;

  assign acc_c[0] = acc_q;
  assign a_c[0]   = a_q;
  assign b_c[0]   = b_q;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
        .mode  (mode_q),
        .acc_i (acc_c[gi]),
        .a_i   (a_c[gi]),
        .b_i   (b_c[gi]),
        .acc_o (acc_c[gi+1]),
        .a_o   (a_c[gi+1]),
        .b_o   (b_c[gi+1])
      );
    end
  endgenerate

  // Product ends up in the accumulator, quotient in the shifted dividend.
  assign result_w = mode_q ? a_c[BITS_PER_CYCLE] : acc_c[BITS_PER_CYCLE];
  assign is_mul   = (bus.ALUSignal == ALU_MUL);
  assign is_div   = (bus.ALUSignal == ALU_DIV);
  assign accept   = bus.start && !bus.flush && (is_mul || is_div);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    aout_d  = aout_q;
    az_d    = az_q;
    rv_d    = rv_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d = is_div;
          acc_d  = '0;
          a_d    = bus.AiA;
          b_d    = bus.AiB;
          cnt_d  = '0;
          if (is_div && (bus.AiB == '0)) begin
            // Divide by zero resolves immediately with an all-ones quotient.
            aout_d  = '1;
            az_d    = 1'b0;
            rv_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          acc_d = acc_c[BITS_PER_CYCLE];
          a_d   = a_c[BITS_PER_CYCLE];
          b_d   = b_c[BITS_PER_CYCLE];
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            aout_d  = result_w;
            az_d    = (result_w == '0);
            rv_d    = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.flush || bus.result_ack) begin
          rv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        rv_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      aout_q  <= '0;
      az_q    <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      aout_q  <= aout_d;
      az_q    <= az_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign bus.Aout         = aout_q;
  assign bus.AZout        = az_q;
  assign bus.result_valid = rv_q;
  assign bus.mode         = mode_q;
  assign bus.busy         = busy_q;
  assign bus.req_ready    = ready_q;

endmodule
